// File: rtl/sa_axi_sched_pkg.sv
// Shared types and helpers for the systolic-array AXI burst scheduler.
package sa_axi_sched_pkg;

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, DONE} sched_state_t;

  localparam int AXI_4K_BYTES = 4096;

  // Largest legal burst: bounded by remaining beats, max burst length and the 4 KB page end.
  function automatic logic [8:0] burst_beats(input logic [11:0] addr,
                                             input logic [31:0] remaining,
                                             input int          max_len,
                                             input int          bytes);
    logic [31:0] room;
    logic [31:0] b;
    room = 32'((AXI_4K_BYTES - int'({20'd0, addr})) / bytes);
    b    = remaining;
    if (b > 32'(max_len)) b = 32'(max_len);
    if (b > room)         b = room;
    return 9'(b);
  endfunction

endpackage

// File: rtl/sa_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched cyclically from a pointer that
// moves past the winner only when grant_en is high.
module sa_rr_arbiter
  import sa_axi_sched_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            gclk,
  input  logic            grst_n,
  input  logic [NREQ-1:0] req,
  input  logic            grant_en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_id,
  output logic            any
);

  logic [IW-1:0] ptr;

  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!any && req[idx]) begin
        any         = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

  always_ff @(posedge gclk) begin
    if (!grst_n)
      ptr <= '0;
    else if (grant_en && any)
      ptr <= (int'(grant_id) == NREQ-1) ? '0 : grant_id + 1'b1;
  end

endmodule

// File: rtl/sa_axi_burst_scheduler.sv
// Splits granted requester transfers into 4 KB-safe AXI INCR bursts and drives
// the AXI master one burst at a time.
module sa_axi_burst_scheduler
  import sa_axi_sched_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_LEN   = 16,
  parameter int BEATS_WIDTH = 16,
  parameter int IW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_write,
  input  logic [NREQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NREQ*BEATS_WIDTH-1:0] req_beats,
  output logic [NREQ-1:0]             req_ack,
  output logic [NREQ-1:0]             req_done,
  output logic [NREQ-1:0]             req_error,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [ADDR_WIDTH-1:0]       cmd_addr,
  output logic [7:0]                  cmd_len,
  output logic                        cmd_write,
  input  logic                        burst_done,
  input  logic                        burst_error,
  output logic                        busy,
  output logic [IW-1:0]               active_id
);

  localparam int BYTES = DATA_WIDTH / 8;

  sched_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [BEATS_WIDTH-1:0] cur_rem;
  logic [8:0]             cur_b;
  logic                   cur_write;
  logic                   err_flag;
  logic [NREQ-1:0]        gnt;
  logic [IW-1:0]          gnt_id;
  logic                   gnt_any;
  logic                   misaligned;
  logic                   last_burst;

  assign misaligned = |(cur_addr & ADDR_WIDTH'(BYTES-1));
  assign last_burst = (cur_rem == BEATS_WIDTH'(cur_b));

  sa_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .gclk     (ACLK),
    .grst_n   (ARESETN),
    .req      (req_valid),
    .grant_en (state == IDLE),
    .grant    (gnt),
    .grant_id (gnt_id),
    .any      (gnt_any)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state     <= IDLE;
      cur_addr  <= '0;
      cur_rem   <= '0;
      cur_b     <= '0;
      cur_write <= 1'b0;
      err_flag  <= 1'b0;
      req_ack   <= '0;
      active_id <= '0;
    end else begin
      state   <= state_nxt;
      req_ack <= '0;
      case (state)
        IDLE: if (gnt_any) begin
          req_ack   <= gnt;
          cur_addr  <= req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
          cur_rem   <= req_beats[gnt_id*BEATS_WIDTH +: BEATS_WIDTH];
          cur_write <= req_write[gnt_id];
          active_id <= gnt_id;
        end
        CALC: begin
          if (misaligned) err_flag <= 1'b1;
          cur_b <= burst_beats(cur_addr[11:0], 32'(cur_rem), BURST_LEN, BYTES);
        end
        WAIT: if (burst_done) begin
          if (burst_error)
            err_flag <= 1'b1;
          else begin
            cur_addr <= cur_addr + ADDR_WIDTH'(cur_b) * ADDR_WIDTH'(BYTES);
            cur_rem  <= cur_rem - BEATS_WIDTH'(cur_b);
          end
        end
        DONE:    err_flag <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (gnt_any) state_nxt = CALC;
      // Zero remaining only occurs on first entry: later entries come from WAIT with work left.
      CALC:  state_nxt = (misaligned || cur_rem == '0) ? DONE : ISSUE;
      ISSUE: if (cmd_ready) state_nxt = WAIT;
      WAIT:  if (burst_done) state_nxt = (burst_error || last_burst) ? DONE : CALC;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state == ISSUE);
    cmd_addr  = cmd_valid ? cur_addr : '0;
    cmd_len   = cmd_valid ? 8'(cur_b - 9'd1) : 8'd0;
    cmd_write = cmd_valid & cur_write;
    busy      = (state != IDLE);
    req_done  = '0;
    req_error = '0;
    if (state == DONE) begin
      req_done[active_id]  = 1'b1;
      req_error[active_id] = err_flag;
    end
  end

endmodule

// File: tb/tb_sa_axi_burst_scheduler.sv
// Directed bench for the AXI burst scheduler: table of single transfers plus
// hand sequences for round-robin, burst error and mid-transfer reset.
module tb_sa_axi_burst_scheduler;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [2:0]  req_valid, req_write, req_ack, req_done, req_error;
  logic [95:0] req_addr;
  logic [47:0] req_beats;
  logic        cmd_valid, cmd_ready, cmd_write, burst_done, burst_error, busy;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [1:0]  active_id;

  sa_axi_burst_scheduler #(.NREQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                           .BURST_LEN(16), .BEATS_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_beats(req_beats), .req_ack(req_ack), .req_done(req_done),
    .req_error(req_error), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_write(cmd_write),
    .burst_done(burst_done), .burst_error(burst_error), .busy(busy),
    .active_id(active_id)
  );

  always #5 ACLK = ~ACLK;

  // Master model: burst_done 4 cycles after acceptance; error on burst index err_burst.
  int mcnt = 0, nburst = 0, err_burst = -1;
  always @(negedge ACLK) begin
    burst_done  = 1'b0;
    burst_error = 1'b0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        burst_done  = 1'b1;
        burst_error = (nburst == err_burst);
        nburst++;
      end
    end
    if (cmd_valid && cmd_ready) mcnt = 4;
  end

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int oh2id(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    int          id;
    bit          wr;
    logic [31:0] addr;
    logic [15:0] beats;
    int          ncmd;
    logic [31:0] a0, a1, a2;
    logic [7:0]  l0, l1, l2;
    bit          err;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] ea[3];
    logic [7:0]  el[3];
    int ncmd = 0, ndone = 0, ack_id = -1, lat = -1, extra = 0;
    ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2;
    el[0] = v.l0; el[1] = v.l1; el[2] = v.l2;
    @(negedge ACLK);
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_write[v.id] = v.wr;
    req_addr[v.id*32 +: 32]  = v.addr;
    req_beats[v.id*16 +: 16] = v.beats;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge ACLK);
      if (|req_ack) begin
        ack_id = oh2id(req_ack);
        req_valid = '0;
      end
      if (cmd_valid) begin
        if (lat < 0) lat = cyc + 1;
        if (ncmd < 3) begin
          chk({tag, ".addr"},  cmd_addr, ea[ncmd]);
          chk({tag, ".len"},   cmd_len,  el[ncmd]);
          chk({tag, ".write"}, cmd_write, v.wr);
          chk({tag, ".id"},    active_id, v.id);
        end
        ncmd++;
      end
      if (|req_done) begin
        ndone++;
        chk({tag, ".done"},  req_done,  3'b1 << v.id);
        chk({tag, ".error"}, req_error, v.err ? (3'b1 << v.id) : 3'b0);
        break;
      end
    end
    chk({tag, ".ack"},   ack_id, v.id);
    chk({tag, ".ncmd"},  ncmd,   v.ncmd);
    chk({tag, ".ndone"}, ndone,  1);
    if (v.ncmd > 0) chk({tag, ".lat"}, lat, 2);
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK);
      if (cmd_valid || (|req_done) || (|req_error)) extra++;
    end
    chk({tag, ".quiet"}, extra, 0);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  vec_t vecs[7];

  initial begin
    vec_t ev;
    int order[6];
    int nack, ndone, cur, extra;
    vecs[0] = '{0, 1'b0, 32'h1000, 16'd40, 3, 32'h1000, 32'h1040, 32'h1080, 8'd15, 8'd15, 8'd7, 1'b0};
    vecs[1] = '{2, 1'b1, 32'h1FF0, 16'd8,  2, 32'h1FF0, 32'h2000, 32'h0,    8'd3,  8'd3,  8'd0, 1'b0};
    vecs[2] = '{1, 1'b0, 32'h0FF8, 16'd5,  2, 32'h0FF8, 32'h1000, 32'h0,    8'd1,  8'd2,  8'd0, 1'b0};
    vecs[3] = '{0, 1'b0, 32'h1000, 16'd0,  0, 32'h0,    32'h0,    32'h0,    8'd0,  8'd0,  8'd0, 1'b0};
    vecs[4] = '{1, 1'b0, 32'h1002, 16'd4,  0, 32'h0,    32'h0,    32'h0,    8'd0,  8'd0,  8'd0, 1'b1};
    vecs[5] = '{2, 1'b1, 32'h0FC0, 16'd16, 1, 32'h0FC0, 32'h0,    32'h0,    8'd15, 8'd0,  8'd0, 1'b0};
    vecs[6] = '{0, 1'b0, 32'hFFFFFFF8, 16'd4, 2, 32'hFFFFFFF8, 32'h0, 32'h0, 8'd1,  8'd1,  8'd0, 1'b0};

    ARESETN = 1'b0; cmd_ready = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_beats = '0;
    repeat (3) @(negedge ACLK);
    chk("reset.outs", {req_ack, req_done, req_error, cmd_valid, cmd_addr, cmd_len,
                       cmd_write, busy, active_id}, 0);
    ARESETN = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Error on the 2nd burst abandons the rest; the next request runs normally.
    err_burst = nburst + 1;
    ev = '{0, 1'b0, 32'h1000, 16'd40, 2, 32'h1000, 32'h1040, 32'h0, 8'd15, 8'd15, 8'd0, 1'b1};
    run_vec(ev, "berr");
    err_burst = -1;
    run_vec(vecs[0], "after_err");

    // Round-robin with all three requesters held.
    do_reset();
    req_valid = 3'b111; req_write = '0;
    req_addr  = {32'h300, 32'h200, 32'h100};
    req_beats = {16'd1, 16'd1, 16'd1};
    nack = 0; ndone = 0; cur = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge ACLK);
      if (|req_ack) begin
        cur = oh2id(req_ack);
        if (nack < 6) order[nack] = cur;
        nack++;
        if (nack == 6) req_valid = '0;
      end
      if (cmd_valid) begin
        chk("rr.id",   active_id, cur);
        chk("rr.addr", cmd_addr,  32'h100 * (cur + 1));
        chk("rr.len",  cmd_len,   0);
      end
      if (|req_done) ndone++;
      if (ndone == 6) break;
    end
    chk("rr.nack",  nack,  6);
    chk("rr.ndone", ndone, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("rr.order%0d", k), order[k], k % 3);

    // Reset while waiting on a burst; the late burst_done must be ignored.
    @(negedge ACLK);
    req_valid = 3'b010; req_write = '0;
    req_addr[32 +: 32] = 32'h1000; req_beats[16 +: 16] = 16'd40;
    cur = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge ACLK);
      if (|req_ack) req_valid = '0;
      if (cmd_valid) begin cur = 1; break; end
    end
    chk("rst.cmd_seen", cur, 1);
    repeat (2) @(negedge ACLK);
    chk("rst.busy_before", busy, 1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    chk("rst.outs", {req_ack, req_done, req_error, cmd_valid, cmd_addr, cmd_len,
                     cmd_write, busy, active_id}, 0);
    ARESETN = 1'b1;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK);
      if (busy || cmd_valid || (|req_done)) extra++;
    end
    chk("rst.ignore_late", extra, 0);
    req_valid = 3'b110;
    req_beats = {16'd1, 16'd1, 16'd1};
    req_addr  = {32'h300, 32'h200, 32'h100};
    cur = -1; ndone = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge ACLK);
      if (|req_ack && cur < 0) begin cur = oh2id(req_ack); req_valid = '0; end
      if (|req_done) begin ndone++; break; end
    end
    chk("rst.first_grant", cur, 1);
    chk("rst.done", ndone, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
